// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for one shared tri-state net, with a forced all-released gap on every owner change.
// Latency: a request seen at a clock edge drives the net from the next cycle. A new owner follows TURNAROUND idle cycles.
// Backpressure: requesters hold req high until granted. The owner leaves on req drop, on done, or at MAX_HOLD when another requester waits.
//
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   req[N_REQ]      level request per requester
//   done[N_REQ]     one-cycle release pulse; only the current owner's bit is used
//   drive_en[N_REQ] one-hot-or-zero tri-state driver enable (registered)
//   owner           index of the current owner, valid while owner_vld; holds its last value otherwise
//   owner_vld       some drive_en bit is high
//   keeper_en       inverse of owner_vld; enables the weak keeper on the net
//   hold_cnt        cycles owned so far by the current owner (saturates at MAX_HOLD)

module shared_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1,
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HW = $clog2(MAX_HOLD) + 1,
    localparam int TW = $clog2(TURNAROUND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  drive_en,
    output logic [OW-1:0]     owner,
    output logic              owner_vld,
    output logic              keeper_en,
    output logic [HW-1:0]     hold_cnt
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t             state, state_nxt;
    logic [OW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [TW-1:0]      turn_cnt, turn_cnt_nxt;
    logic [N_REQ-1:0]   drive_en_nxt;
    logic [OW-1:0]      owner_nxt;
    logic [HW-1:0]      hold_cnt_nxt;

    logic               win_found;
    logic [OW-1:0]      win_idx;
    logic               release_bus;

    // Round-robin search: first set req bit starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    // drive_en is the owner's one-hot while in OWN, so req & ~drive_en gives
    // exactly the other requesters that are waiting.
    always_comb begin
        release_bus = !req[owner] || done[owner] ||
                      ((hold_cnt == HW'(MAX_HOLD)) && ((req & ~drive_en) != '0));
    end

    always_comb begin
        state_nxt    = state;
        drive_en_nxt = drive_en;
        owner_nxt    = owner;
        hold_cnt_nxt = hold_cnt;
        rr_ptr_nxt   = rr_ptr;
        turn_cnt_nxt = turn_cnt;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt             = OWN;
                    drive_en_nxt          = '0;
                    drive_en_nxt[win_idx] = 1'b1;
                    owner_nxt             = win_idx;
                    hold_cnt_nxt          = HW'(1);
                    rr_ptr_nxt            = (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + OW'(1);
                end
            end
            OWN: begin
                if (release_bus) begin
                    state_nxt    = TURN;
                    drive_en_nxt = '0;
                    hold_cnt_nxt = '0;
                    turn_cnt_nxt = '0;
                end else if (hold_cnt != HW'(MAX_HOLD)) begin
                    hold_cnt_nxt = hold_cnt + HW'(1);
                end
            end
            TURN: begin
                // Requests are only sampled on the final turnaround cycle, so
                // ones that rise during the gap still compete.
                if (turn_cnt == TW'(TURNAROUND - 1)) begin
                    if (win_found) begin
                        state_nxt             = OWN;
                        drive_en_nxt          = '0;
                        drive_en_nxt[win_idx] = 1'b1;
                        owner_nxt             = win_idx;
                        hold_cnt_nxt          = HW'(1);
                        rr_ptr_nxt            = (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + OW'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    turn_cnt_nxt = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                drive_en_nxt = '0;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            drive_en  <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            keeper_en <= 1'b1;
            hold_cnt  <= '0;
            rr_ptr    <= '0;
            turn_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            drive_en  <= drive_en_nxt;
            owner     <= owner_nxt;
            owner_vld <= (state_nxt == OWN);
            keeper_en <= (state_nxt != OWN);
            hold_cnt  <= hold_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            turn_cnt  <= turn_cnt_nxt;
        end
    end

endmodule
